// File: rtl/evm_pkg.sv
// Shared definitions for the voting-machine front end: FSM encoding and
// candidate one-hot codes.
package evm_pkg;

   localparam int NUM_CAND = 3;

   localparam logic [NUM_CAND-1:0] CAND_P1 = 3'b001;
   localparam logic [NUM_CAND-1:0] CAND_P2 = 3'b010;
   localparam logic [NUM_CAND-1:0] CAND_P3 = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_CAST    = 3'd2,
      S_CONFIRM = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   // A voter must identify as exactly one gender for the vote to count.
   function automatic logic gender_valid(input logic male, input logic female);
      return male ^ female;
   endfunction

endpackage

// File: rtl/ballot_input_controller_if.sv
// Vote bus towards the EVM counter. Strobe-only protocol: voting_en is a
// one-cycle valid with no ready; voter_switch and gender are valid only with it.
interface ballot_input_controller_if;
   import evm_pkg::*;

   logic [NUM_CAND-1:0] voter_switch;
   logic                voting_en;
   logic                gender_in_male;
   logic                gender_in_female;

   modport master (
      output voter_switch,
      output voting_en,
      output gender_in_male,
      output gender_in_female
   );

   modport slave (
      input voter_switch,
      input voting_en,
      input gender_in_male,
      input gender_in_female
   );

endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a stability filter: the output level
// follows the synchronized input only after DEBOUNCE_CYCLES identical samples.
module input_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic level_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q counts consecutive samples that disagree with the current level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/ballot_input_controller.sv
// Booth front end: turns officer key, candidate buttons and gender switches
// into a single clean vote strobe per released ballot.
module ballot_input_controller
   import evm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 64,
   parameter int CONFIRM_CYCLES  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ballot_key,
   input  logic [NUM_CAND-1:0]       cand_btn,
   input  logic                      male_sw,
   input  logic                      female_sw,
   ballot_input_controller_if.master evm,
   output logic                      ready_led,
   output logic                      confirm_led,
   output logic                      multi_press,
   output logic                      timeout,
   output logic [7:0]                ballots_cast,
   output state_t                    state_dbg
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int FW = (CONFIRM_CYCLES > 1) ? $clog2(CONFIRM_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] CFM_LAST = FW'(CONFIRM_CYCLES - 1);

   logic [NUM_CAND-1:0] db_btn, db_prev_q, new_press;
   logic                db_male, db_female;
   logic                key_s1_q, key_s2_q, key_prev_q, key_rise;

   for (genvar i = 0; i < NUM_CAND; i++) begin : g_btn
      input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
         .clk(clk), .rst(rst), .raw_i(cand_btn[i]), .level_o(db_btn[i])
      );
   end

   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_male (
      .clk(clk), .rst(rst), .raw_i(male_sw), .level_o(db_male)
   );

   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_female (
      .clk(clk), .rst(rst), .raw_i(female_sw), .level_o(db_female)
   );

   assign key_rise  = key_s2_q & ~key_prev_q;
   assign new_press = db_btn & ~db_prev_q;

   state_t              state_q, state_d;
   logic [NUM_CAND-1:0] cand_q, cand_d;
   logic                male_q, male_d, female_q, female_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [FW-1:0]       cfm_q, cfm_d;
   logic                multi_d, tmo_pulse_d;

   logic [NUM_CAND-1:0] voter_switch_q;
   logic                voting_en_q, g_male_q, g_female_q;
   logic                ready_q, confirm_q, multi_q, timeout_q;
   logic [7:0]          ballots_q;

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      male_d      = male_q;
      female_d    = female_q;
      tmo_d       = tmo_q;
      cfm_d       = cfm_q;
      multi_d     = 1'b0;
      tmo_pulse_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            tmo_d = '0;
            if (key_rise && (db_btn == '0)) state_d = S_ARMED;
         end
         S_ARMED: begin
            // Multi-press wins over a fresh single press in the same cycle.
            if ($countones(db_btn) > 1) begin
               multi_d = 1'b1;
               state_d = S_RELEASE;
            end else if ($onehot(new_press) && gender_valid(db_male, db_female)) begin
               cand_d   = new_press;
               male_d   = db_male;
               female_d = db_female;
               state_d  = S_CAST;
            end else if (tmo_q == TMO_LAST) begin
               tmo_pulse_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_CAST: begin
            cfm_d   = '0;
            state_d = S_CONFIRM;
         end
         S_CONFIRM: begin
            if (cfm_q == CFM_LAST) state_d = S_RELEASE;
            else                   cfm_d   = cfm_q + FW'(1);
         end
         S_RELEASE: begin
            if (db_btn == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_s1_q       <= 1'b0;
         key_s2_q       <= 1'b0;
         key_prev_q     <= 1'b0;
         db_prev_q      <= '0;
         state_q        <= S_IDLE;
         cand_q         <= '0;
         male_q         <= 1'b0;
         female_q       <= 1'b0;
         tmo_q          <= '0;
         cfm_q          <= '0;
         voter_switch_q <= '0;
         voting_en_q    <= 1'b0;
         g_male_q       <= 1'b0;
         g_female_q     <= 1'b0;
         ready_q        <= 1'b0;
         confirm_q      <= 1'b0;
         multi_q        <= 1'b0;
         timeout_q      <= 1'b0;
         ballots_q      <= '0;
      end else begin
         key_s1_q       <= ballot_key;
         key_s2_q       <= key_s1_q;
         key_prev_q     <= key_s2_q;
         db_prev_q      <= db_btn;
         state_q        <= state_d;
         cand_q         <= cand_d;
         male_q         <= male_d;
         female_q       <= female_d;
         tmo_q          <= tmo_d;
         cfm_q          <= cfm_d;
         voter_switch_q <= (state_d == S_CAST) ? cand_d : '0;
         voting_en_q    <= (state_d == S_CAST);
         g_male_q       <= (state_d == S_CAST) & male_d;
         g_female_q     <= (state_d == S_CAST) & female_d;
         ready_q        <= (state_d == S_ARMED);
         confirm_q      <= (state_d == S_CONFIRM);
         multi_q        <= multi_d;
         timeout_q      <= tmo_pulse_d;
         if ((state_d == S_CAST) && (ballots_q != 8'hFF)) ballots_q <= ballots_q + 8'd1;
      end
   end

   assign evm.voter_switch     = voter_switch_q;
   assign evm.voting_en        = voting_en_q;
   assign evm.gender_in_male   = g_male_q;
   assign evm.gender_in_female = g_female_q;
   assign ready_led            = ready_q;
   assign confirm_led          = confirm_q;
   assign multi_press          = multi_q;
   assign timeout              = timeout_q;
   assign ballots_cast         = ballots_q;
   assign state_dbg            = state_q;

endmodule

// File: tb/tb_ballot_input_controller.sv
// Directed bench for ballot_input_controller: clean vote, repeat vote,
// multi-press, bounce/timeout, invalid gender and reset during CONFIRM.
module tb_ballot_input_controller;
   import evm_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       ballot_key;
   logic [2:0] cand_btn;
   logic       male_sw, female_sw;
   logic       ready_led, confirm_led, multi_press, timeout;
   logic [7:0] ballots_cast;
   state_t     state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   int         vote_cnt, first_vote, confirm_cnt, multi_cnt, timeout_cnt, first_timeout;
   logic [2:0] vs_cap;
   logic       male_cap, female_cap;

   always #5 clk = ~clk;

   ballot_input_controller_if evm ();

   ballot_input_controller dut (
      .clk          (clk),
      .rst          (rst),
      .ballot_key   (ballot_key),
      .cand_btn     (cand_btn),
      .male_sw      (male_sw),
      .female_sw    (female_sw),
      .evm          (evm),
      .ready_led    (ready_led),
      .confirm_led  (confirm_led),
      .multi_press  (multi_press),
      .timeout      (timeout),
      .ballots_cast (ballots_cast),
      .state_dbg    (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Key held high 4 cycles: the synchronized edge arms the FSM at the 3rd edge.
   task automatic arm();
      ballot_key = 1'b1;
      cycles(4);
      ballot_key = 1'b0;
   endtask

   // Observes n negedges after the current one; drops buttons at rel_at and
   // toggles cand_btn[0] every 2 cycles when toggle is set.
   task automatic window(input int n, input int rel_at, input bit toggle);
      vote_cnt = 0; first_vote = -1; confirm_cnt = 0;
      multi_cnt = 0; timeout_cnt = 0; first_timeout = -1;
      vs_cap = '0; male_cap = 1'b0; female_cap = 1'b0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (evm.voting_en) begin
            vote_cnt++;
            if (first_vote < 0) begin
               first_vote = i;
               vs_cap     = evm.voter_switch;
               male_cap   = evm.gender_in_male;
               female_cap = evm.gender_in_female;
            end
         end
         if (confirm_led) confirm_cnt++;
         if (multi_press) multi_cnt++;
         if (timeout) begin
            timeout_cnt++;
            if (first_timeout < 0) first_timeout = i;
         end
         if (i == rel_at) cand_btn = '0;
         if (toggle && (i % 2 == 0)) cand_btn[0] = ~cand_btn[0];
      end
   endtask

   initial begin
      rst = 1'b1; ballot_key = 1'b0; cand_btn = '0; male_sw = 1'b0; female_sw = 1'b0;
      cycles(3);
      check("rst_state", 32'(state_dbg), 32'(S_IDLE));
      check("rst_ven", 32'(evm.voting_en), 32'd0);
      check("rst_ballots", 32'(ballots_cast), 32'd0);
      rst = 1'b0;
      cycles(2);

      // Clean vote: male, party2
      male_sw = 1'b1;
      cycles(8);
      arm();
      check("arm_ready", 32'(ready_led), 32'd1);
      cand_btn = CAND_P2;
      window(20, 10, 1'b0);
      check("clean_votes", 32'(vote_cnt), 32'd1);
      check("clean_latency", 32'(first_vote), 32'd7);
      check("clean_vs", 32'(vs_cap), 32'(CAND_P2));
      check("clean_male", 32'(male_cap), 32'd1);
      check("clean_female", 32'(female_cap), 32'd0);
      check("clean_confirm", 32'(confirm_cnt), 32'd8);
      check("clean_ballots", 32'(ballots_cast), 32'd1);
      check("clean_idle", 32'(state_dbg), 32'(S_IDLE));

      // Second press without a new ballot
      cand_btn = CAND_P1;
      window(20, 10, 1'b0);
      check("dbl_votes", 32'(vote_cnt), 32'd0);
      check("dbl_ballots", 32'(ballots_cast), 32'd1);

      // Key edge while a button is held is ignored
      cand_btn = CAND_P1;
      cycles(8);
      arm();
      check("held_key_ready", 32'(ready_led), 32'd0);
      cand_btn = '0;
      cycles(8);

      // Multi-press
      arm();
      cand_btn = 3'b011;
      window(10, 0, 1'b0);
      check("multi_pulse", 32'(multi_cnt), 32'd1);
      check("multi_votes", 32'(vote_cnt), 32'd0);
      check("multi_held_state", 32'(state_dbg), 32'(S_RELEASE));
      cand_btn = '0;
      window(10, 0, 1'b0);
      check("multi_rel_state", 32'(state_dbg), 32'(S_IDLE));
      check("multi_ballots", 32'(ballots_cast), 32'd1);

      // Bouncing button until the ballot times out
      arm();
      cand_btn = CAND_P1;
      window(70, 0, 1'b1);
      cand_btn = '0;
      check("bounce_votes", 32'(vote_cnt), 32'd0);
      check("bounce_multi", 32'(multi_cnt), 32'd0);
      check("tmo_pulse", 32'(timeout_cnt), 32'd1);
      check("tmo_cycle", 32'(first_timeout), 32'd63);
      check("tmo_ready", 32'(ready_led), 32'd0);
      cycles(8);

      // Invalid gender, then corrected
      female_sw = 1'b1;
      cycles(8);
      arm();
      cand_btn = CAND_P1;
      window(15, 10, 1'b0);
      check("gbad_votes", 32'(vote_cnt), 32'd0);
      check("gbad_state", 32'(state_dbg), 32'(S_ARMED));
      female_sw = 1'b0;
      cycles(8);
      cand_btn = CAND_P3;
      window(20, 10, 1'b0);
      check("gfix_votes", 32'(vote_cnt), 32'd1);
      check("gfix_latency", 32'(first_vote), 32'd7);
      check("gfix_vs", 32'(vs_cap), 32'(CAND_P3));
      check("gfix_male", 32'(male_cap), 32'd1);
      check("gfix_female", 32'(female_cap), 32'd0);
      check("gfix_ballots", 32'(ballots_cast), 32'd2);

      // Reset in the middle of CONFIRM
      arm();
      cand_btn = CAND_P2;
      cycles(10);
      check("pre_rst_confirm", 32'(confirm_led), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
      check("mid_rst_confirm", 32'(confirm_led), 32'd0);
      check("mid_rst_ven", 32'(evm.voting_en), 32'd0);
      check("mid_rst_vs", 32'(evm.voter_switch), 32'd0);
      check("mid_rst_ready", 32'(ready_led), 32'd0);
      check("mid_rst_ballots", 32'(ballots_cast), 32'd0);
      cand_btn = '0;
      cycles(2);
      rst = 1'b0;
      cycles(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
